// File: rtl/spike_encoder.sv
// Differential spike-train encoder: each accepted word becomes one fixed-shape frame.
// The frame is synchronous bursts, then one staggered pulse per channel, then a rest period.
module spike_encoder #(
  parameter int N_CH    = 2,
  parameter int N_BURST = 3,
  parameter int GAP     = 2,
  parameter int REST    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N_CH-1:0] p_out,
  output logic [N_CH-1:0] n_out,
  output logic            busy,
  output logic            done
);

  localparam int BC_W_RAW = $clog2(N_BURST + 1);
  localparam int BC_W     = (BC_W_RAW < 1) ? 1 : BC_W_RAW;
  localparam int CH_W_RAW = $clog2(N_CH + 1);
  localparam int CH_W     = (CH_W_RAW < 1) ? 1 : CH_W_RAW;
  localparam int TM_MAX   = (GAP > REST) ? GAP : REST;
  localparam int TM_W_RAW = $clog2(TM_MAX + 1);
  localparam int TM_W     = (TM_W_RAW < 1) ? 1 : TM_W_RAW;

  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(N_BURST - 1);
  localparam logic [BC_W-1:0] BC_ONE     = BC_W'(1);
  localparam logic [CH_W-1:0] CH_LAST    = CH_W'(N_CH - 1);
  localparam logic [CH_W-1:0] CH_ONE     = CH_W'(1);
  localparam logic [TM_W-1:0] GAP_LAST   = TM_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [TM_W-1:0] REST_LAST  = TM_W'((REST > 0) ? REST - 1 : 0);
  localparam logic [TM_W-1:0] TM_ONE     = TM_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BURST   = 3'd1,
    ST_B_GAP   = 3'd2,
    ST_STAGGER = 3'd3,
    ST_S_GAP   = 3'd4,
    ST_REST    = 3'd5
  } state_t;

  state_t          state_r, state_s;
  logic [N_CH-1:0] data_r, data_s;
  logic [BC_W-1:0] burst_r, burst_s;
  logic [CH_W-1:0] ch_r, ch_s;
  logic [TM_W-1:0] timer_r, timer_s;
  logic            burst_exit_s;
  logic            stagger_exit_s;
  logic            accept_s;
  logic            last_s;
  logic [N_CH-1:0] ch_mask_s;
  logic [N_CH-1:0] p_s, n_s;

  assign in_ready = (state_r == ST_IDLE) && !rst;
  assign accept_s = in_valid && in_ready;

  // Next-state and counter logic; gap/rest exits are folded into two shared exit paths.
  always_comb begin
    state_s        = state_r;
    data_s         = data_r;
    burst_s        = burst_r;
    ch_s           = ch_r;
    timer_s        = timer_r;
    burst_exit_s   = 1'b0;
    stagger_exit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_BURST;
          data_s  = in_data;
          burst_s = '0;
          ch_s    = '0;
          timer_s = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (GAP == 0) begin
          burst_exit_s = 1'b1;
        end else begin
          state_s = ST_B_GAP;
          timer_s = '0;
        end
      end
      ST_B_GAP: begin
        if (timer_r == GAP_LAST) begin
          burst_exit_s = 1'b1;
        end else begin
          timer_s = timer_r + TM_ONE;
        end
      end
      ST_STAGGER: begin
        if (GAP == 0) begin
          stagger_exit_s = 1'b1;
        end else begin
          state_s = ST_S_GAP;
          timer_s = '0;
        end
      end
      ST_S_GAP: begin
        if (timer_r == GAP_LAST) begin
          stagger_exit_s = 1'b1;
        end else begin
          timer_s = timer_r + TM_ONE;
        end
      end
      ST_REST: begin
        if (timer_r == REST_LAST) begin
          state_s = ST_IDLE;
        end else begin
          timer_s = timer_r + TM_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (burst_exit_s) begin
      if (burst_r == BURST_LAST) begin
        state_s = ST_STAGGER;
        ch_s    = '0;
      end else begin
        state_s = ST_BURST;
        burst_s = burst_r + BC_ONE;
      end
    end else begin
      burst_s = burst_s;
    end

    if (stagger_exit_s) begin
      if (ch_r != CH_LAST) begin
        state_s = ST_STAGGER;
        ch_s    = ch_r + CH_ONE;
      end else if (REST == 0) begin
        state_s = ST_IDLE;
      end else begin
        state_s = ST_REST;
        timer_s = '0;
      end
    end else begin
      ch_s = ch_s;
    end
  end

  // Output values for the cycle being entered, so the registered outputs line up with the state.
  always_comb begin
    p_s = '0;
    n_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_mask_s[i] = (ch_s == CH_W'(i));
    end
    case (state_s)
      ST_BURST: begin
        p_s = data_s;
        n_s = ~data_s;
      end
      ST_STAGGER: begin
        p_s = data_s & ch_mask_s;
        n_s = ~data_s & ch_mask_s;
      end
      default: begin
        p_s = '0;
        n_s = '0;
      end
    endcase
    // The last frame cycle moves earlier into S_GAP or STAGGER when REST (and GAP) are zero.
    last_s = ((state_s == ST_REST) && (timer_s == REST_LAST)) ||
             ((REST == 0) && (GAP != 0) && (state_s == ST_S_GAP) &&
              (timer_s == GAP_LAST) && (ch_s == CH_LAST)) ||
             ((REST == 0) && (GAP == 0) && (state_s == ST_STAGGER) && (ch_s == CH_LAST));
  end

  // State, counters and registered outputs; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      data_r  <= '0;
      burst_r <= '0;
      ch_r    <= '0;
      timer_r <= '0;
      p_out   <= '0;
      n_out   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      data_r  <= data_s;
      burst_r <= burst_s;
      ch_r    <= ch_s;
      timer_r <= timer_s;
      p_out   <= p_s;
      n_out   <= n_s;
      busy    <= (state_s != ST_IDLE);
      done    <= last_s;
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Scoreboard bench for spike_encoder: default instance plus a GAP=0/REST=0/N_BURST=1/N_CH=3 instance.
module tb_spike_encoder;

  typedef struct packed {
    logic [7:0] p;
    logic [7:0] n;
    logic       busy;
    logic       done;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] p_out, n_out;
  logic       busy, done;

  logic [2:0] alt_data;
  logic       alt_valid;
  logic       alt_ready;
  logic [2:0] alt_p, alt_n;
  logic       alt_busy, alt_done;

  int vectors = 0;
  int miscompares = 0;

  exp_t q_main[$];
  exp_t q_alt[$];

  spike_encoder dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .p_out(p_out), .n_out(n_out), .busy(busy), .done(done)
  );

  spike_encoder #(.N_CH(3), .N_BURST(1), .GAP(0), .REST(0)) dut_alt (
    .clk(clk), .rst(rst), .in_data(alt_data), .in_valid(alt_valid), .in_ready(alt_ready),
    .p_out(alt_p), .n_out(alt_n), .busy(alt_busy), .done(alt_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs at frame cycle t (1..len), derived from the frame arithmetic.
  function automatic exp_t expect_at(input int nch, input int nb, input int g, input int len,
                                     input logic [7:0] w, input int t);
    exp_t e;
    int per, t0, off, c;
    logic [7:0] mask, one;
    e = '0;
    if (t == 0) return e;
    per  = 1 + g;
    t0   = t - 1;
    mask = 8'((1 << nch) - 1);
    e.busy = 1'b1;
    e.done = (t == len);
    if (t0 < nb * per) begin
      if (t0 % per == 0) begin
        e.p = w & mask;
        e.n = ~w & mask;
      end
    end else begin
      off = t0 - nb * per;
      if (off < nch * per && off % per == 0) begin
        c   = off / per;
        one = 8'(1 << c);
        e.p = w & one;
        e.n = ~w & one;
      end
    end
    return e;
  endfunction

  task automatic model_step(input int nch, input int nb, input int g, input int rs,
                            input logic r, input logic v, input logic [7:0] d,
                            inout int t, inout logic [7:0] w, output exp_t e);
    int len;
    len = nb * (1 + g) + nch * (1 + g) + rs;
    if (r) t = 0;
    else if (t == 0 && v) begin
      t = 1;
      w = d;
    end else if (t > 0 && t < len) t = t + 1;
    else t = 0;
    e = expect_at(nch, nb, g, len, w, t);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference models: one expected record per clock edge for each instance.
  initial begin
    int t_m, t_a;
    logic [7:0] w_m, w_a;
    exp_t e;
    t_m = 0; t_a = 0; w_m = 8'd0; w_a = 8'd0;
    forever begin
      @(posedge clk);
      model_step(2, 3, 2, 5, rst, in_valid, {6'd0, in_data}, t_m, w_m, e);
      q_main.push_back(e);
      model_step(3, 1, 0, 0, rst, alt_valid, {5'd0, alt_data}, t_a, w_a, e);
      q_alt.push_back(e);
    end
  end

  // Monitors: pop and compare on the falling edge, plus the pulse invariants.
  initial begin
    exp_t e;
    logic [1:0] prev_p, prev_n;
    prev_p = 2'b00; prev_n = 2'b00;
    forever begin
      @(negedge clk);
      if (q_main.size() > 0) begin
        e = q_main.pop_front();
        check("p_out", {6'd0, p_out}, {6'd0, e.p[1:0]});
        check("n_out", {6'd0, n_out}, {6'd0, e.n[1:0]});
        check("busy", {7'd0, busy}, {7'd0, e.busy});
        check("done", {7'd0, done}, {7'd0, e.done});
        check("in_ready", {7'd0, in_ready}, {7'd0, !e.busy && !rst});
        check("p_and_n", {6'd0, p_out & n_out}, 8'd0);
        check("pulse_width", {4'd0, p_out & prev_p, n_out & prev_n}, 8'd0);
        prev_p = p_out;
        prev_n = n_out;
      end
      if (q_alt.size() > 0) begin
        e = q_alt.pop_front();
        check("alt_p", {5'd0, alt_p}, {5'd0, e.p[2:0]});
        check("alt_n", {5'd0, alt_n}, {5'd0, e.n[2:0]});
        check("alt_busy", {7'd0, alt_busy}, {7'd0, e.busy});
        check("alt_done", {7'd0, alt_done}, {7'd0, e.done});
        check("alt_ready", {7'd0, alt_ready}, {7'd0, !e.busy && !rst});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 2'b00; alt_valid = 1'b0; alt_data = 3'b000;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Single word 00 on the main instance, 101 on the alternate one.
    in_data = 2'b00; in_valid = 1'b1;
    alt_data = 3'b101; alt_valid = 1'b1;
    tick(1);
    in_valid = 1'b0; alt_valid = 1'b0;
    tick(25);

    // Words held valid continuously: back-to-back frames.
    in_valid = 1'b1; in_data = 2'b01;
    tick(10);
    in_data = 2'b10;
    tick(21);
    in_data = 2'b11;
    tick(15);
    in_valid = 1'b0;
    tick(25);

    // Random valid/data toggling, including during frames.
    repeat (300) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 2'($urandom);
      alt_valid = 1'($urandom_range(0, 1));
      alt_data  = 3'($urandom);
      tick(1);
    end
    in_valid = 1'b0; alt_valid = 1'b0;
    tick(25);

    // Reset in the middle of a frame, then a clean new word.
    in_data = 2'b10; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(7);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    in_data = 2'($urandom); in_valid = 1'b1;
    alt_data = 3'($urandom); alt_valid = 1'b1;
    tick(1);
    in_valid = 1'b0; alt_valid = 1'b0;
    tick(25);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
